rx: RTL and testbench
=====================

RX -- requirements
Module: rx

Interface
REQ-001 SHALL have parameter DELIM_MIN, default 16: minimum delimiter low time in clk cycles.
REQ-002 SHALL have port clk, input, 1: single clock; all logic on its rising edge.
REQ-003 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-004 SHALL have port demodin, input, 1: asynchronous demodulated PIE envelope; low = pulse.
REQ-005 SHALL have port bitout, output, 1: last decoded data bit.
REQ-006 SHALL have port bitclk, output, 1: one-cycle strobe marking a new bitout.
REQ-007 SHALL have port rx_overflow_reset, output, 1: one-cycle pulse on frame timeout.
REQ-008 SHALL have port rngbitout, output, 1: random bit taken from interval-count LSB.
REQ-009 SHALL have port trcal, output, 10: last measured TRcal length in clk cycles.
REQ-010 SHALL have port count, output, 10: live interval counter value.

Function
REQ-011 SHALL synchronize demodin through a 2-flop chain (s1, s2), then a third register s3 for edge detection.
- rise = s2 & ~s3
- fall = ~s2 & s3
REQ-012 SHALL increment count every cycle, saturating at 1023.
- On each qualifying edge below, capture L = count, then load count = 1.
- L is therefore the exact cycle distance between edge detections.
REQ-013 SHALL implement states IDLE, DELIM, DATA0, RTCAL, CAL2, BITS.
REQ-014 IDLE: fall -> load count, go to DELIM.
REQ-015 DELIM: rise with L >= DELIM_MIN -> load count, go to DATA0.
- Rise with L < DELIM_MIN -> go to IDLE.
REQ-016 DATA0: rise -> L discarded (data-0 length), go to RTCAL.
REQ-017 RTCAL: rise -> store rtcal = L and pivot = L >> 1, go to CAL2.
REQ-018 CAL2: rise -> if L > rtcal, set trcal = L, emit no bit; otherwise decode L as a data bit per REQ-019.
- Either way, go to BITS.
REQ-019 BITS (and the CAL2 data case): on rise, register bitout = (L >= pivot) and pulse bitclk high for exactly one cycle.
- bitclk rises in the cycle after rise detection, i.e. the 3rd clk edge after demodin is first sampled high.
REQ-020 SHALL register rngbitout = count[0] (pre-load value) on every rise detection in any state.
REQ-021 When count reaches 1023 in any state except IDLE, SHALL:
- pulse rx_overflow_reset high for exactly one cycle,
- return to IDLE.
- rx_overflow_reset SHALL never assert in IDLE.
REQ-022 bitout and trcal SHALL hold their values until next updated; trcal persists across frames.
REQ-023 Falls SHALL be ignored in all states except IDLE.

Reset
REQ-024 While reset is high at a clk edge, SHALL force:
- state = IDLE
- count, trcal, rtcal, pivot = 0
- bitout, bitclk, rx_overflow_reset, rngbitout = 0
- s1, s2, s3 = 1 (idle-high line)
REQ-025 Reset asserted mid-frame SHALL abort decoding with no bitclk pulse in the following cycle.

Verification
REQ-026 Frame decode: demodin idle high, 24 low (delimiter), data-0 = 24 high + 24 low, RTcal = 96 high + 24 low, then symbols 48, 72, 48 -> rtcal = 120, pivot = 60; bits 0,1,0 with three single-cycle bitclk pulses.
REQ-027 TRcal: same preamble, then a 200-cycle symbol -> trcal = 200 and no bitclk; a following 72-cycle symbol -> bitout = 1.
REQ-028 Short delimiter: 10-cycle low pulse from idle -> state back to IDLE; no bitclk; trcal unchanged.
REQ-029 Timeout: valid preamble, then demodin held high -> count saturates at 1023; one rx_overflow_reset pulse; later frames decode normally.
REQ-030 Reset mid-frame: reset asserted during BITS -> all outputs 0 on the next edge; a new delimiter decodes correctly.
REQ-031 rngbitout: after each rise, rngbitout equals the LSB of the measured L (e.g. L = 49 -> 1).

Source files
------------

// File: rtl/rx.sv
// rtl/rx.sv - PIE envelope receiver: delimiter/RTcal/TRcal framing and data bit decode
module rx #(
  parameter int DELIM_MIN = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       demodin,
  output logic       bitout,
  output logic       bitclk,
  output logic       rx_overflow_reset,
  output logic       rngbitout,
  output logic [9:0] trcal,
  output logic [9:0] count
);

  localparam logic [9:0] DMIN    = 10'(DELIM_MIN);
  localparam logic [9:0] CNT_MAX = 10'd1023;

  typedef enum logic [2:0] {IDLE, DELIM, DATA0, RTCAL, CAL2, BITS} state_t;

  state_t     state, next_state;
  logic       s1, s2, s3;
  logic       rise, fall;
  logic [9:0] rtcal, pivot;
  logic       timeout, load, set_rtcal, set_trcal, emit;

  // Edge detect on the synchronized envelope
  assign rise = s2 & ~s3;
  assign fall = ~s2 & s3;

  // A saturated interval counter outside IDLE means the frame stalled
  assign timeout = (state != IDLE) && (count == CNT_MAX);

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Next-state logic; timeout wins over any edge in the same cycle
  always_comb begin
    next_state = state;
    if (timeout) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE:    if (fall) next_state = DELIM;
        DELIM:   if (rise) next_state = (count >= DMIN) ? DATA0 : IDLE;
        DATA0:   if (rise) next_state = RTCAL;
        RTCAL:   if (rise) next_state = CAL2;
        CAL2:    if (rise) next_state = BITS;
        BITS:    next_state = BITS;
        default: next_state = IDLE;
      endcase
    end
  end

  // Output/control decode: which datapath updates the current edge triggers
  always_comb begin
    load      = 1'b0;
    set_rtcal = 1'b0;
    set_trcal = 1'b0;
    emit      = 1'b0;
    if (!timeout) begin
      load      = (state == IDLE) ? fall : rise;
      set_rtcal = (state == RTCAL) && rise;
      set_trcal = (state == CAL2) && rise && (count > rtcal);
      emit      = rise && ((state == BITS) || ((state == CAL2) && (count <= rtcal)));
    end
  end

  // Datapath: synchronizer, interval counter, calibration and bit registers
  always_ff @(posedge clk) begin
    if (reset) begin
      s1                <= 1'b1;
      s2                <= 1'b1;
      s3                <= 1'b1;
      count             <= '0;
      rtcal             <= '0;
      pivot             <= '0;
      trcal             <= '0;
      bitout            <= 1'b0;
      bitclk            <= 1'b0;
      rx_overflow_reset <= 1'b0;
      rngbitout         <= 1'b0;
    end else begin
      s1 <= demodin;
      s2 <= s1;
      s3 <= s2;
      if (load)                 count <= 10'd1;
      else if (count != CNT_MAX) count <= count + 10'd1;
      if (set_rtcal) begin
        rtcal <= count;
        pivot <= count >> 1;
      end
      if (set_trcal) trcal  <= count;
      if (emit)      bitout <= (count >= pivot);
      bitclk            <= emit;
      rx_overflow_reset <= timeout;
      if (rise) rngbitout <= count[0];
    end
  end

endmodule

// File: tb/tb_rx.sv
// tb/tb_rx.sv - directed self-checking bench for rx
module tb_rx;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       demodin = 1'b1;
  logic       bitout, bitclk, rx_overflow_reset, rngbitout;
  logic [9:0] trcal, count;

  int vectors = 0;
  int miscompares = 0;

  int   nclk = 0, wide_clk = 0, nov = 0, wide_ov = 0;
  logic prev_clk = 1'b0, prev_ov = 1'b0;
  logic bq[$];

  rx #(.DELIM_MIN(16)) dut (
    .clk(clk),
    .reset(reset),
    .demodin(demodin),
    .bitout(bitout),
    .bitclk(bitclk),
    .rx_overflow_reset(rx_overflow_reset),
    .rngbitout(rngbitout),
    .trcal(trcal),
    .count(count)
  );

  always #5 clk = ~clk;

  // Pulse monitor: records decoded bits and pulse widths at the falling edge
  always @(negedge clk) begin
    if (!reset) begin
      if (bitclk) begin
        bq.push_back(bitout);
        nclk++;
        if (prev_clk) wide_clk++;
      end
      if (rx_overflow_reset) begin
        nov++;
        if (prev_ov) wide_ov++;
      end
    end
    prev_clk = bitclk;
    prev_ov  = rx_overflow_reset;
  end

  task automatic drive(input logic v, input int n);
    demodin = v;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    demodin = 1'b1;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    drive(1'b1, 3);
  endtask

  task automatic preamble();
    drive(1'b0, 24);
    drive(1'b1, 24);
    drive(1'b0, 24);
    drive(1'b1, 96);
    drive(1'b0, 24);
  endtask

  task automatic symbol(input int n);
    drive(1'b1, n - 24);
    drive(1'b0, 24);
  endtask

  task automatic test_reset();
    demodin = 1'b1;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if ({bitout, bitclk, rx_overflow_reset, rngbitout, trcal, count} !== 14'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %b/%b/%b/%b trcal=%0d count=%0d, want all 0",
               bitout, bitclk, rx_overflow_reset, rngbitout, trcal, count);
    end
    reset = 1'b0;
    drive(1'b1, 3);
  endtask

  task automatic test_frame();
    int c0;
    bq.delete();
    c0 = nclk;
    preamble();
    symbol(48);
    symbol(72);
    symbol(48);
    demodin = 1'b1;
    for (int e = 1; e <= 4; e++) begin
      @(posedge clk);
      #1;
      vectors++;
      if (bitclk !== (e == 3)) begin
        miscompares++;
        $display("FAIL frame_bitclk_edge%0d: got %b want %b", e, bitclk, (e == 3));
      end
    end
    drive(1'b1, 4);
    vectors++;
    if (nclk - c0 != 3 || bq.size() != 3) begin
      miscompares++;
      $display("FAIL frame_pulses: got %0d pulses, want 3", nclk - c0);
    end else begin
      vectors++;
      if (bq[0] !== 1'b0 || bq[1] !== 1'b1 || bq[2] !== 1'b0) begin
        miscompares++;
        $display("FAIL frame_bits: got %b%b%b want 010", bq[0], bq[1], bq[2]);
      end
    end
    vectors++;
    if (wide_clk != 0) begin
      miscompares++;
      $display("FAIL bitclk_width: got %0d wide pulses, want 0", wide_clk);
    end
  endtask

  task automatic test_trcal();
    int c0;
    do_reset();
    preamble();
    c0 = nclk;
    symbol(200);
    drive(1'b1, 6);
    vectors++;
    if (trcal !== 10'd200) begin
      miscompares++;
      $display("FAIL trcal_value: got %0d want 200", trcal);
    end
    vectors++;
    if (nclk != c0) begin
      miscompares++;
      $display("FAIL trcal_nobit: got %0d pulses want 0", nclk - c0);
    end
    drive(1'b1, 42);
    drive(1'b0, 24);
    drive(1'b1, 6);
    vectors++;
    if (bitout !== 1'b1 || nclk != c0 + 1) begin
      miscompares++;
      $display("FAIL trcal_next_bit: got bitout=%b pulses=%0d want 1/1", bitout, nclk - c0);
    end
  endtask

  task automatic test_timeout();
    int o0;
    int waited;
    o0 = nov;
    waited = 0;
    demodin = 1'b1;
    while (nov == o0 && waited < 1200) begin
      @(posedge clk);
      #1;
      waited++;
    end
    vectors++;
    if (nov == o0) begin
      miscompares++;
      $display("FAIL timeout_wait: got no overflow pulse in %0d cycles, want one", waited);
    end
    drive(1'b1, 50);
    vectors++;
    if (nov != o0 + 1 || wide_ov != 0) begin
      miscompares++;
      $display("FAIL timeout_pulse: got %0d pulses (%0d wide), want 1 single-cycle", nov - o0, wide_ov);
    end
    vectors++;
    if (count !== 10'd1023) begin
      miscompares++;
      $display("FAIL timeout_count: got %0d want 1023", count);
    end
  endtask

  task automatic test_short_delim();
    int c0, o0;
    c0 = nclk;
    o0 = nov;
    drive(1'b0, 10);
    drive(1'b1, 40);
    vectors++;
    if (nclk != c0 || trcal !== 10'd200 || nov != o0) begin
      miscompares++;
      $display("FAIL short_delim: got pulses=%0d trcal=%0d ovf=%0d want 0/200/0",
               nclk - c0, trcal, nov - o0);
    end
  endtask

  task automatic test_rng();
    do_reset();
    preamble();
    symbol(49);
    drive(1'b1, 4);
    vectors++;
    if (rngbitout !== 1'b1 || bitout !== 1'b0) begin
      miscompares++;
      $display("FAIL rng_49: got rng=%b bit=%b want 1/0", rngbitout, bitout);
    end
    drive(1'b1, 22);
    drive(1'b0, 24);
    drive(1'b1, 4);
    vectors++;
    if (rngbitout !== 1'b0 || bitout !== 1'b0) begin
      miscompares++;
      $display("FAIL rng_50: got rng=%b bit=%b want 0/0", rngbitout, bitout);
    end
    drive(1'b1, 47);
    drive(1'b0, 24);
    drive(1'b1, 4);
    vectors++;
    if (rngbitout !== 1'b1 || bitout !== 1'b1) begin
      miscompares++;
      $display("FAIL rng_75: got rng=%b bit=%b want 1/1", rngbitout, bitout);
    end
  endtask

  task automatic test_reset_mid_frame();
    int c0;
    do_reset();
    preamble();
    symbol(72);
    drive(1'b1, 24);
    vectors++;
    if (bitout !== 1'b1) begin
      miscompares++;
      $display("FAIL midreset_setup: got bitout=%b want 1", bitout);
    end
    drive(1'b0, 10);
    demodin = 1'b1;
    @(posedge clk);
    #1;
    c0 = nclk;
    reset = 1'b1;
    @(posedge clk);
    #1;
    vectors++;
    if ({bitout, bitclk, rx_overflow_reset, rngbitout, trcal, count} !== 14'd0) begin
      miscompares++;
      $display("FAIL midreset_outputs: got %b/%b/%b/%b trcal=%0d count=%0d, want all 0",
               bitout, bitclk, rx_overflow_reset, rngbitout, trcal, count);
    end
    reset = 1'b0;
    drive(1'b1, 5);
    vectors++;
    if (nclk != c0) begin
      miscompares++;
      $display("FAIL midreset_nobit: got %0d pulses want 0", nclk - c0);
    end
    bq.delete();
    preamble();
    symbol(72);
    symbol(48);
    drive(1'b1, 6);
    vectors++;
    if (bq.size() != 2) begin
      miscompares++;
      $display("FAIL midreset_refr: got %0d bits want 2", bq.size());
    end else begin
      vectors++;
      if (bq[0] !== 1'b1 || bq[1] !== 1'b0) begin
        miscompares++;
        $display("FAIL midreset_bits: got %b%b want 10", bq[0], bq[1]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_trcal();
    test_timeout();
    test_short_delim();
    test_frame();
    test_rng();
    test_reset_mid_frame();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
